// File: rtl/mod4051_residue_acc.sv
// mod4051_residue_acc
// Folds a stream of 12-bit partial residues (one per 6-bit operand chunk,
// produced by the residue LUT stage) into a single residue modulo MODULUS.
// The result is presented once the beat flagged in_last has been accepted.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   in_valid/ready   input beat handshake; in_ready depends on state only
//   in_data          partial residue
//   in_last          marks the final chunk of the operand
//   out_valid/ready  result handshake; outputs held while out_ready=0
//   out_data         final residue in [0, MODULUS-1]
//   out_count        beats accepted for the operand (wraps mod 2^CNT_W)
//   out_err          sticky out-of-range flag for the operand
//
// Optional feature macro: MOD4051_ACC_RANGE_CHECK_EN
//   defined   : in_data >= MODULUS is pre-reduced and flagged on out_err
//   undefined : in_data must be < MODULUS, out_err tied 0
module mod4051_residue_acc #(
  parameter int MODULUS = 4051,
  parameter int W       = 12,
  parameter int CNT_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err
);

  localparam logic [W-1:0] MOD_W  = W'(MODULUS);
  localparam logic [W:0]   MOD_W1 = (W+1)'(MODULUS);

  typedef enum logic {ACC, DONE} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     acc;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     d_red;
  logic [W:0]       s;
  logic [W-1:0]     acc_nxt;
  logic             accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  assign accept = in_valid && in_ready;

`ifdef MOD4051_ACC_RANGE_CHECK_EN
  logic in_ge;
  logic err;
  logic out_err_q;

  // in_data < 2^W < 2*MODULUS, so one subtract brings it into range.
  assign in_ge = (in_data >= MOD_W);
  assign d_red = in_ge ? (in_data - MOD_W) : in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err       <= 1'b0;
      out_err_q <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        out_err_q <= err | in_ge;
        err       <= 1'b0;
      end else begin
        err <= err | in_ge;
      end
    end
  end

  assign out_err = out_err_q;
`else
  assign d_red   = in_data;
  assign out_err = 1'b0;
`endif

  // Both operands are < MODULUS, so the sum is < 2*MODULUS. The subtract
  // is done at W bits: the true difference is < 2^W, so truncation is exact.
  assign s       = {1'b0, acc} + {1'b0, d_red};
  assign acc_nxt = (s >= MOD_W1) ? (s[W-1:0] - MOD_W) : s[W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_count <= '0;
    end else if (accept) begin
      if (in_last) begin
        out_data  <= acc_nxt;
        out_count <= cnt + CNT_W'(1);
        acc       <= '0;
        cnt       <= '0;
      end else begin
        acc <= acc_nxt;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mod4051_residue_acc.sv
module tb_mod4051_residue_acc;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [6:0]  out_count;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  mod4051_residue_acc #(.MODULUS(4051), .W(12), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_beat(input logic [11:0] d, input logic l);
    int g = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (in_ready !== 1'b1 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    checks++;
    if (g >= 50) begin
      errors++;
      $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid();
    int g = 0;
    while (out_valid !== 1'b1 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    checks++;
    if (g >= 50) begin
      errors++;
      $display("FAIL result_timeout: out_valid %b, required 1", out_valid);
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", in_ready); end
    checks++; if (out_data !== 12'd0) begin errors++; $display("FAIL reset_data: got %0d required 0", out_data); end
    checks++; if (out_count !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", out_count); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", out_err); end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    send_beat(12'd4050, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL early_valid: got %b required 0", out_valid); end
    send_beat(12'd1, 1'b1);
    // one-cycle latency: valid already high right after the accepting edge
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_valid: got %b required 1", out_valid); end
    checks++; if (out_data !== 12'd0) begin errors++; $display("FAIL basic_data: got %0d required 0", out_data); end
    checks++; if (out_count !== 7'd2) begin errors++; $display("FAIL basic_count: got %0d required 2", out_count); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b required 0", out_err); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL done_ready: got %b required 0", in_ready); end
    release_result();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_valid: got %b required 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b required 1", in_ready); end

    send_beat(12'd4050, 1'b0);
    send_beat(12'd4050, 1'b1);
    wait_valid();
    checks++; if (out_data !== 12'd4049) begin errors++; $display("FAIL wrap_data: got %0d required 4049", out_data); end
    checks++; if (out_count !== 7'd2) begin errors++; $display("FAIL wrap_count: got %0d required 2", out_count); end
    release_result();
  endtask

  task automatic test_hold();
    send_beat(12'd2000, 1'b0);
    send_beat(12'd2051, 1'b0);
    send_beat(12'd7, 1'b1);
    wait_valid();
    checks++; if (out_data !== 12'd7) begin errors++; $display("FAIL three_data: got %0d required 7", out_data); end
    checks++; if (out_count !== 7'd3) begin errors++; $display("FAIL three_count: got %0d required 3", out_count); end
    in_valid = 1'b1; in_data = 12'd1000; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b required 1", i, out_valid); end
      checks++; if (out_data !== 12'd7) begin errors++; $display("FAIL hold_data[%0d]: got %0d required 7", i, out_data); end
      checks++; if (out_count !== 7'd3) begin errors++; $display("FAIL hold_count[%0d]: got %0d required 3", i, out_count); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d]: got %b required 0", i, in_ready); end
    end
    in_valid = 1'b0;
    release_result();
    send_beat(12'd12, 1'b1);
    wait_valid();
    checks++; if (out_data !== 12'd12) begin errors++; $display("FAIL after_hold_data: got %0d required 12", out_data); end
    checks++; if (out_count !== 7'd1) begin errors++; $display("FAIL after_hold_count: got %0d required 1", out_count); end
    release_result();
  endtask

  task automatic test_full_operand();
    logic [503:0] op;
    int golden, pw, chunk, gaps;
    op = '0;
    for (int i = 0; i < 16; i++) op[i*32 +: 32] = $urandom;
    op[503:500] = '0;
    golden = 0;
    for (int b = 499; b >= 0; b--) golden = (golden * 2 + int'(op[b])) % 4051;
    pw = 1;
    for (int i = 0; i < 84; i++) begin
      chunk = int'(op[i*6 +: 6]);
      send_beat(12'((chunk * pw) % 4051), (i == 83) ? 1'b1 : 1'b0);
      pw = (pw * 64) % 4051;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin @(posedge clk); #1; end
    end
    wait_valid();
    checks++; if (int'(out_data) !== golden) begin errors++; $display("FAIL full_data: got %0d required %0d", out_data, golden); end
    checks++; if (out_count !== 7'd84) begin errors++; $display("FAIL full_count: got %0d required 84", out_count); end
    release_result();

    for (int i = 0; i < 128; i++) send_beat(12'd1, (i == 127) ? 1'b1 : 1'b0);
    wait_valid();
    checks++; if (out_data !== 12'd128) begin errors++; $display("FAIL long_data: got %0d required 128", out_data); end
    checks++; if (out_count !== 7'd0) begin errors++; $display("FAIL long_count: got %0d required 0", out_count); end
    release_result();
  endtask

  task automatic test_reset_mid();
    send_beat(12'd100, 1'b0);
    send_beat(12'd200, 1'b0);
    send_beat(12'd300, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b required 0", out_valid); end
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    send_beat(12'd5, 1'b1);
    wait_valid();
    checks++; if (out_data !== 12'd5) begin errors++; $display("FAIL midrst_data: got %0d required 5", out_data); end
    checks++; if (out_count !== 7'd1) begin errors++; $display("FAIL midrst_count: got %0d required 1", out_count); end
    // reset while the result is pending drops it asynchronously
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL donerst_valid: got %b required 0", out_valid); end
    checks++; if (out_data !== 12'd0) begin errors++; $display("FAIL donerst_data: got %0d required 0", out_data); end
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL donerst_ready: got %b required 1", in_ready); end
  endtask

`ifdef MOD4051_ACC_RANGE_CHECK_EN
  task automatic test_range_check();
    send_beat(12'd4095, 1'b0);
    send_beat(12'd10, 1'b1);
    wait_valid();
    checks++; if (out_data !== 12'd54) begin errors++; $display("FAIL range_data: got %0d required 54", out_data); end
    checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL range_err: got %b required 1", out_err); end
    release_result();
    send_beat(12'd3, 1'b1);
    wait_valid();
    checks++; if (out_data !== 12'd3) begin errors++; $display("FAIL range_next_data: got %0d required 3", out_data); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL range_next_err: got %b required 0", out_err); end
    release_result();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_full_operand();
    test_reset_mid();
`ifdef MOD4051_ACC_RANGE_CHECK_EN
    test_range_check();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
